// File: rtl/frame_sequencer.sv
// frame_sequencer: frame scheduler for the serial telemetry path.
// Emits SYNC1, SYNC2, an optional frame-count word and num_word data words,
// one parallel-load strobe every WORD_W clocks, and pulls data words from an
// upstream valid/ready source one cycle ahead of each data-word load.
// Optional feature: define FRAME_SEQ_FCNT_EN to insert the frame-count word
// between SYNC2 and the data words.
`timescale 1ns/1ps

module frame_sequencer #(
  parameter int unsigned       WORD_W = 16,
  parameter logic [WORD_W-1:0] SYNC1  = 16'hFE6B,
  parameter logic [WORD_W-1:0] SYNC2  = 16'h2840,
  parameter logic [WORD_W-1:0] FILL   = 16'hAAAA
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [15:0]       num_word,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              load,
  output logic              signal_f1,
  output logic              signal_f2,
  output logic              signal_d,
  output logic              frame_start,
  output logic [15:0]       frame_count
);

  localparam int unsigned      CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] PRE   = CNT_W'(WORD_W - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC1,
    S_SYNC2,
`ifdef FRAME_SEQ_FCNT_EN
    S_FCNT,
`endif
    S_DATA
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [15:0]       nw_lat;
  logic [15:0]       word_idx;

  logic              boundary;
  logic              frame_end;
  logic              pre_data;
  logic              start;
  logic [WORD_W-1:0] next_data;

  // Decode word boundary, end of frame and whether the next word is a data word
  always_comb begin
    frame_end = 1'b0;
    pre_data  = 1'b0;
    case (state)
      S_SYNC2: begin
`ifdef FRAME_SEQ_FCNT_EN
        frame_end = 1'b0;
        pre_data  = 1'b0;
`else
        frame_end = (nw_lat == '0);
        pre_data  = (nw_lat != '0);
`endif
      end
`ifdef FRAME_SEQ_FCNT_EN
      S_FCNT: begin
        frame_end = (nw_lat == '0);
        pre_data  = (nw_lat != '0);
      end
`endif
      S_DATA: begin
        frame_end = (word_idx == nw_lat - 16'd1);
        pre_data  = (word_idx != nw_lat - 16'd1);
      end
      default: ;
    endcase
    boundary  = (state != S_IDLE) && (bit_cnt == LAST);
    start     = enable && ((state == S_IDLE) || (boundary && frame_end));
    // data_ready is high only in the boundary cycle before a data word
    next_data = (data_ready && data_valid) ? data_in : FILL;
  end

  // Frame state machine; all word, strobe and flag outputs are registered
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      nw_lat      <= '0;
      word_idx    <= '0;
      word_out    <= '0;
      load        <= 1'b0;
      signal_f1   <= 1'b0;
      signal_f2   <= 1'b0;
      signal_d    <= 1'b0;
      data_ready  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      load        <= 1'b0;
      frame_start <= 1'b0;
      data_ready  <= 1'b0;

      if (state != S_IDLE) begin
        bit_cnt <= boundary ? '0 : bit_cnt + CNT_W'(1);
        if (bit_cnt == PRE)
          data_ready <= pre_data;
      end

      if (boundary && frame_end)
        frame_count <= frame_count + 16'd1;

      if (start) begin
        // Back-to-back frames restart here without a gap cycle
        state       <= S_SYNC1;
        nw_lat      <= num_word;
        word_out    <= SYNC1;
        load        <= 1'b1;
        frame_start <= 1'b1;
        signal_f1   <= 1'b1;
        signal_f2   <= 1'b0;
        signal_d    <= 1'b0;
      end else if (boundary) begin
        if (frame_end) begin
          state     <= S_IDLE;
          signal_f1 <= 1'b0;
          signal_f2 <= 1'b0;
          signal_d  <= 1'b0;
        end else begin
          load <= 1'b1;
          case (state)
            S_SYNC1: begin
              state     <= S_SYNC2;
              word_out  <= SYNC2;
              signal_f1 <= 1'b0;
              signal_f2 <= 1'b1;
            end
            S_SYNC2: begin
`ifdef FRAME_SEQ_FCNT_EN
              state     <= S_FCNT;
              word_out  <= WORD_W'(frame_count);
              signal_f2 <= 1'b0;
`else
              state     <= S_DATA;
              word_idx  <= '0;
              word_out  <= next_data;
              signal_f2 <= 1'b0;
              signal_d  <= 1'b1;
`endif
            end
`ifdef FRAME_SEQ_FCNT_EN
            S_FCNT: begin
              state    <= S_DATA;
              word_idx <= '0;
              word_out <= next_data;
              signal_d <= 1'b1;
            end
`endif
            S_DATA: begin
              word_idx <= word_idx + 16'd1;
              word_out <= next_data;
            end
            default: begin
              state <= S_IDLE;
              load  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
